// File: rtl/cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_loader
// Brief    : Byte-serial bitstream loader that assembles 77-bit tile frames
//            and writes them to the tile array through one-hot strobes.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_loader #(
    parameter int NUM_TILES = 4,
    parameter int FRAME_W   = 77
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FRAME_W-1:0]   bits,
    output logic [NUM_TILES-1:0] wr_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int         C_ASM_W     = FRAME_W - 5;
    localparam logic [7:0] C_MAGIC     = 8'hA5;
    localparam logic [7:0] C_NUM_TILES = 8'(NUM_TILES);
    localparam logic [3:0] C_LAST_BYTE = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_FRAME = 3'd2,
        S_WRITE = 3'd3,
        S_CSUM  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_ready;
    logic                 w_accept;
    logic [C_ASM_W-1:0]   r_shift;
    logic [FRAME_W-1:0]   r_bits;
    logic [7:0]           r_count;
    logic [7:0]           r_tile_idx;
    logic [3:0]           r_byte_idx;
    logic [7:0]           r_csum;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (in_valid && in_data == C_MAGIC) w_next = S_COUNT;
            end
            S_COUNT: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == 8'd0 || in_data > C_NUM_TILES) w_next = S_ERR;
                    else                                          w_next = S_FRAME;
                end
            end
            S_FRAME: begin
                w_ready = 1'b1;
                if (in_valid && r_byte_idx == C_LAST_BYTE) begin
                    if (in_data[7:5] != 3'd0) w_next = S_ERR;
                    else                      w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_tile_idx == r_count - 8'd1) w_next = S_CSUM;
                else                              w_next = S_FRAME;
            end
            S_CSUM: begin
                w_ready = 1'b1;
                if (in_valid) w_next = S_IDLE;
            end
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Ready is forced low while reset is asserted so no byte is lost to reset.
    assign in_ready = w_ready && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bits     <= '0;
            r_count    <= '0;
            r_tile_idx <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && in_data == C_MAGIC) begin
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        r_count    <= in_data;
                        r_tile_idx <= '0;
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                    end
                end
                S_FRAME: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ in_data;
                        r_byte_idx <= r_byte_idx + 4'd1;
                        for (int k = 0; k < 9; k++) begin
                            if (r_byte_idx == 4'(k)) r_shift[8*k +: 8] <= in_data;
                        end
                        // The output register only moves when a clean frame completes.
                        if (r_byte_idx == C_LAST_BYTE && in_data[7:5] == 3'd0)
                            r_bits <= {in_data[4:0], r_shift};
                    end
                end
                S_WRITE: begin
                    r_tile_idx <= r_tile_idx + 8'd1;
                    r_byte_idx <= '0;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (in_data == r_csum) r_done <= 1'b1;
                        else                   r_err  <= 1'b1;
                    end
                end
                S_ERR: begin
                    r_err  <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_wr_en
            assign wr_en[gi] = (r_state == S_WRITE) && (r_tile_idx == 8'(gi));
        end
    endgenerate

    assign bits = r_bits;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_loader
// Brief    : Directed-vector bench for cfg_loader with a write-strobe log.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_loader;

    localparam int NT = 4;
    localparam int FW = 77;
    localparam logic [FW-1:0] C_F0 = 77'h0A_0908_0706_0504_0302_01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] bits;
    logic [NT-1:0] wr_en;
    logic          busy;
    logic          done;
    logic          err;

    cfg_loader #(.NUM_TILES(NT), .FRAME_W(FW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bits     (bits),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT-1:0] we;
        logic [FW-1:0] b;
    } wr_t;

    wr_t wlog[$];
    always @(negedge clk) if (wr_en != '0) wlog.push_back({wr_en, bits});

    int n_vec   = 0;
    int n_err   = 0;
    int gap_max = 0;

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL handshake_timeout byte=%02h in_ready=%b required 1", b, in_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, bits, wr_en, busy, done, err} !== '0) begin
            n_err++;
            $display("FAIL reset_values rdy=%b bits=%h wr_en=%b busy=%b done=%b err=%b required all 0",
                     in_ready, bits, wr_en, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_reset got %b required 1", in_ready);
        end
    endtask

    task automatic test_nominal(input string tag);
        #1 wlog.delete();
        send(8'hA5);
        n_vec++;
        if ({busy, done, err} !== 3'b100) begin
            n_err++; $display("FAIL %s_busy_after_magic busy/done/err=%b required 100", tag, {busy, done, err});
        end
        send(8'h02);
        for (int i = 1; i <= 10; i++) send(8'(i));
        for (int i = 0; i < 10; i++) send(8'h00);
        send(8'h0B);
        n_vec++;
        if ({busy, done, err} !== 3'b010) begin
            n_err++; $display("FAIL %s_status busy/done/err=%b required 010", tag, {busy, done, err});
        end
        idle(2);
        n_vec++;
        if (wlog.size() != 2) begin
            n_err++; $display("FAIL %s_write_count got %0d required 2", tag, wlog.size());
        end else begin
            n_vec++;
            if (wlog[0] !== {4'b0001, C_F0}) begin
                n_err++; $display("FAIL %s_frame0 got we=%b bits=%h required we=0001 bits=%h", tag, wlog[0].we, wlog[0].b, C_F0);
            end
            n_vec++;
            if (wlog[1] !== {4'b0010, 77'h0}) begin
                n_err++; $display("FAIL %s_frame1 got we=%b bits=%h required we=0010 bits=0", tag, wlog[1].we, wlog[1].b);
            end
        end
    endtask

    task automatic test_garbage;
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL garbage_busy got %b required 0", busy);
        end
        test_nominal("garbage");
    endtask

    task automatic test_bad_count(input logic [7:0] cnt);
        #1 wlog.delete();
        send(8'hA5);
        send(cnt);
        idle(2);
        n_vec++;
        if ({busy, done, err} !== 3'b001 || wlog.size() != 0) begin
            n_err++; $display("FAIL bad_count_%02h busy/done/err=%b writes=%0d required 001 writes=0",
                              cnt, {busy, done, err}, wlog.size());
        end
    endtask

    task automatic test_csum_err;
        #1 wlog.delete();
        send(8'hA5);
        send(8'h02);
        for (int i = 1; i <= 10; i++) send(8'(i));
        for (int i = 0; i < 10; i++) send(8'h00);
        send(8'h0C);
        n_vec++;
        if ({busy, done, err} !== 3'b001) begin
            n_err++; $display("FAIL csum_err_status busy/done/err=%b required 001", {busy, done, err});
        end
        idle(2);
        n_vec++;
        if (wlog.size() != 2) begin
            n_err++; $display("FAIL csum_err_writes got %0d required 2", wlog.size());
        end
    endtask

    task automatic test_reserved;
        #1 wlog.delete();
        send(8'hA5);
        send(8'h02);
        for (int i = 1; i <= 9; i++) send(8'(i));
        send(8'h2A);
        idle(2);
        n_vec++;
        if ({busy, done, err} !== 3'b001 || wlog.size() != 0) begin
            n_err++; $display("FAIL reserved_bits busy/done/err=%b writes=%0d required 001 writes=0",
                              {busy, done, err}, wlog.size());
        end
    endtask

    task automatic test_max_tiles;
        logic [7:0]    v;
        logic [FW-1:0] exp_b;
        #1 wlog.delete();
        send(8'hA5);
        send(8'h04);
        for (int f = 1; f <= 4; f++) for (int i = 0; i < 10; i++) send(8'(f));
        send(8'h00);
        idle(2);
        n_vec++;
        if ({busy, done, err} !== 3'b010 || wlog.size() != 4) begin
            n_err++; $display("FAIL max_tiles_status busy/done/err=%b writes=%0d required 010 writes=4",
                              {busy, done, err}, wlog.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                v = 8'(f + 1);
                exp_b = {v[4:0], {9{v}}};
                n_vec++;
                if (wlog[f] !== {4'(1 << f), exp_b}) begin
                    n_err++; $display("FAIL max_tiles_frame%0d got we=%b bits=%h required we=%b bits=%h",
                                      f, wlog[f].we, wlog[f].b, 4'(1 << f), exp_b);
                end
            end
        end
    endtask

    task automatic test_magic_data;
        #1 wlog.delete();
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 9; i++) send(8'hA5);
        send(8'h05);
        send(8'hA0);
        idle(2);
        n_vec++;
        if ({busy, done, err} !== 3'b010 || wlog.size() != 1) begin
            n_err++; $display("FAIL magic_data_status busy/done/err=%b writes=%0d required 010 writes=1",
                              {busy, done, err}, wlog.size());
        end else begin
            n_vec++;
            if (wlog[0] !== {4'b0001, 5'h05, {9{8'hA5}}}) begin
                n_err++; $display("FAIL magic_data_frame got we=%b bits=%h", wlog[0].we, wlog[0].b);
            end
        end
    endtask

    task automatic test_reset_mid;
        send(8'hA5);
        send(8'h02);
        for (int i = 1; i <= 5; i++) send(8'(i));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({in_ready, bits, wr_en, busy, done, err} !== '0) begin
            n_err++; $display("FAIL reset_mid_outputs rdy=%b bits=%h wr_en=%b busy=%b done=%b err=%b required all 0",
                              in_ready, bits, wr_en, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        test_nominal("after_reset");
    endtask

    task automatic test_back_to_back;
        gap_max = 3;
        test_nominal("backpressure");
        gap_max = 0;
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_garbage();
        test_bad_count(8'h00);
        test_bad_count(8'h05);
        test_csum_err();
        test_reserved();
        test_max_tiles();
        test_magic_data();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cfg_loader.md
# cfg_loader

Configuration loader for the tile array. It accepts a byte-serial bitstream over a valid/ready stream and assembles 77-bit tile configuration frames. Each frame is written to one tile through a one-hot write-enable pulse with a shared `bits` bus. It validates the stream header, the frame count, the reserved bits and an XOR checksum, and reports `done` or `err`.

## Interface
- `NUM_TILES`, default 4: number of tiles on the config bus, range 1..255.
- `FRAME_W`, default 77: configuration frame width per tile; fixed at 77.
- `clk`, in, 1: single clock; all logic is clocked on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_data`, in, 8: bitstream byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: loader accepts a byte. Transfer happens when `in_valid && in_ready` at the rising edge.
- `bits`, out, FRAME_W: configuration frame broadcast to all tiles.
- `wr_en`, out, NUM_TILES: one-hot write strobe; bit i writes tile i.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: the last load completed with a good checksum. Sticky.
- `err`, out, 1: the last load aborted or failed. Sticky.

## Operation
- **Stream format:** magic 0xA5, then count byte N, then N frames of 10 bytes each, then a checksum byte.
- **Frame byte order:** byte k (k = 0..8) loads `bits[8k+7:8k]`. Byte 9 loads `bits[76:72]` from `in_data[4:0]`. `in_data[7:5]` of byte 9 is reserved and must be 0.
- **Checksum:** XOR of all 10·N frame bytes. Header and count bytes are excluded.
- **Tile order:** frame i goes to tile i, for i = 0..N-1.
- **Buffering:** an internal shift/assembly register is separate from the `bits` output register. `bits` changes only on entry to WRITE and holds until the next WRITE.
- **States:**
  - IDLE: `in_ready`=1. Byte 0xA5 → COUNT; it clears `done`/`err` and sets `busy`. Any other byte is discarded.
  - COUNT: `in_ready`=1. N == 0 or N > NUM_TILES → ERR. Otherwise latch N, tile_idx=0, byte_idx=0, csum=0 → FRAME.
  - FRAME: `in_ready`=1. Each accepted byte is stored and XORed into csum, and byte_idx increments. On byte 9:
    - reserved bits nonzero → ERR;
    - otherwise load `bits` from the assembled frame → WRITE.
  - WRITE: `in_ready`=0 and `wr_en[tile_idx]`=1 for exactly one cycle. Then tile_idx increments and byte_idx=0.
    - If tile_idx was N-1 → CSUM.
    - Otherwise → FRAME.
  - CSUM: `in_ready`=1. Byte == csum → IDLE with `done`=1. Mismatch → IDLE with `err`=1. `busy`=0 in both cases.
  - ERR (one cycle): `err`=1, `busy`=0 → IDLE.
- **No rollback:** tiles already written are not rolled back on a later error; software must reload.
- **Magic inside a load:** a 0xA5 byte received in COUNT, FRAME or CSUM is data, not a restart.
- **`wr_en`:** never has more than one bit set; it is all-zero outside WRITE.

## Timing
- **Reset values:** `bits`=0, `wr_en`=0, `busy`=0, `done`=0, `err`=0, state IDLE. `in_ready`=0 while `rst` is high and 1 in the first cycle after.
- **Write latency:** byte 9 accepted at edge t → `wr_en` high and new `bits` valid in cycle t..t+1. `in_ready` is low in that cycle and high again from edge t+1.
- **Throughput:** 11 cycles per frame with `in_valid` held high.
- **Status latency:**
  - `done`/`err` are set at the edge that accepts the checksum byte.
  - A bad count or bad reserved bits: `err` is set one edge after the offending byte (ERR state).
- **Stalls:** `in_valid` gaps stall the FSM with no state change. `bits` and `wr_en` are unaffected.
- **Reset mid-operation:** `rst` takes priority at any edge. `wr_en` is 0 in the next cycle, the partial frame and csum are discarded, and all flags clear.

## Test plan
- **Nominal 2-tile load:** A5, 02, bytes 01..0A, ten 00, 0B.
  - `bits`=0x0A_0908_0706_0504_0302_01 with `wr_en`=0001 for 1 cycle.
  - Then `bits`=0 with `wr_en`=0010.
  - `done`=1, `err`=0, `busy`=0.
- **Garbage prefix:** 00, FF, 5A, then the nominal stream → bytes ignored, identical result.
- **Bad count:**
  - count 00 → `err`=1, no `wr_en`.
  - count 05 with NUM_TILES=4 → `err`=1, no `wr_en`.
- **Checksum error:** nominal stream with checksum 0C → both `wr_en` pulses occur, then `err`=1, `done`=0.
- **Reserved bits:** byte 9 = 0x2A → `err`=1, no `wr_en`.
- **Backpressure and reset:**
  - Random `in_valid` gaps give the same `bits`/`wr_en` sequence.
  - `rst` after byte 4 of frame 0 → all outputs 0; a fresh nominal stream then loads correctly.
